// File: rtl/img_pkt_check.sv
// img_pkt_check: pops packed frames from a standard FIFO, forwards image words and
// checks the trailer (XOR parity, format, frame-counter sequence) per packet.
module img_pkt_check #(
  parameter int LINE_SIZE  = 1024,
  parameter int IMAGE_SIZE = 1024*1024,
  parameter int PIX_SIZE   = 8,
  parameter     PKT_MODE   = "2D"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] fifo_rddata,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [1:0]  frame_type,
  output logic [31:0] frame_id,
  output logic        parity_err,
  output logic        fmt_err,
  output logic        seq_err,
  output logic [15:0] err_cnt
);
  localparam int WPW = 32 / PIX_SIZE;
  localparam int DW  = IMAGE_SIZE / WPW;
  localparam int TW  = LINE_SIZE / WPW;
  localparam int TOT = DW + TW;
  localparam int CW  = $clog2(TOT) + 1;
  localparam logic [7:0] MODE = (PKT_MODE == "2D") ? 8'd0 : 8'd1;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, INFO, PAD, REPORT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] iss_q, wcnt_q, off;
  logic rd_vld_q, first_q, perr_q, ferr_q, perr_w, ferr_w, seq_w, fin, any_err;
  logic [31:0] xor_q, id_q, id_w;
  logic [1:0] type_q;
  assign off        = wcnt_q - CW'(DW);
  assign fifo_rden  = state_q != IDLE && state_q != REPORT && !fifo_empty && iss_q < CW'(TOT);
  assign frame_done = state_q == REPORT;
  assign id_w       = (rd_vld_q && state_q == INFO && off == CW'(7)) ? fifo_rddata : id_q;
  assign seq_w      = !first_q && id_w != frame_id + 32'd1;
  assign fin        = state_d == REPORT && state_q != REPORT;
  assign perr_w     = rd_vld_q && state_q == PARITY && off == '0 && fifo_rddata != xor_q;
  assign any_err    = perr_q || perr_w || ferr_q || ferr_w || seq_w;
  always_comb begin
    state_d = state_q;
    ferr_w  = 1'b0;
    case (state_q)
      IDLE:    state_d = en ? DATA : IDLE;
      DATA:    state_d = (rd_vld_q && wcnt_q == CW'(DW - 1)) ? PARITY : DATA;
      PARITY: begin
        ferr_w  = rd_vld_q && off != '0 && fifo_rddata != '0;
        state_d = (rd_vld_q && off == CW'(3)) ? INFO : PARITY;
      end
      INFO: begin
        ferr_w  = rd_vld_q && (off == CW'(4) ? (fifo_rddata[31:10] != '0 || fifo_rddata[7:0] != MODE)
                                             : off != CW'(7) && fifo_rddata != '0);
        state_d = (rd_vld_q && off == CW'(7)) ? ((TW == 8) ? REPORT : PAD) : INFO;
      end
      PAD: begin
        ferr_w  = rd_vld_q && fifo_rddata != '0;
        state_d = (rd_vld_q && off == CW'(TW - 1)) ? REPORT : PAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iss_q      <= '0;
      wcnt_q     <= '0;
      rd_vld_q   <= 1'b0;
      xor_q      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      first_q    <= 1'b1;
      id_q       <= '0;
      type_q     <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      frame_type <= '0;
      frame_id   <= '0;
      parity_err <= 1'b0;
      fmt_err    <= 1'b0;
      seq_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= fifo_rden;
      iss_q     <= state_q == IDLE ? '0 : iss_q + CW'(fifo_rden);
      wcnt_q    <= state_q == IDLE ? '0 : wcnt_q + CW'(rd_vld_q);
      xor_q     <= state_q == IDLE ? '0 : (state_q == DATA && rd_vld_q) ? xor_q ^ fifo_rddata : xor_q;
      perr_q    <= state_q != IDLE && (perr_q || perr_w);
      ferr_q    <= state_q != IDLE && (ferr_q || ferr_w);
      id_q      <= id_w;
      type_q    <= (rd_vld_q && state_q == INFO && off == CW'(4)) ? fifo_rddata[9:8] : type_q;
      pix_valid <= rd_vld_q && state_q == DATA;
      pix_data  <= (rd_vld_q && state_q == DATA) ? fifo_rddata : pix_data;
      // status is latched on the edge into REPORT so it is valid alongside frame_done
      if (fin) begin
        first_q    <= 1'b0;
        frame_type <= type_q;
        frame_id   <= id_w;
        parity_err <= perr_q || perr_w;
        fmt_err    <= ferr_q || ferr_w;
        seq_err    <= seq_w;
        err_cnt    <= (any_err && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
      end
    end
  end
endmodule
